// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  localparam int unsigned INST_SIZE_DEFAULT = 32;
  localparam int unsigned BYTES_PER_WORD    = INST_SIZE_DEFAULT / 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } loader_state_e;

  // Bytes per instruction word for an arbitrary word width.
  function automatic int unsigned bytes_per_word(input int unsigned inst_size);
    return inst_size / 8;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects a little-endian byte stream into instruction words.
// word_next is the register contents with the incoming byte already placed at
// the current index, so the owner can capture a complete word on the cycle its
// last byte is accepted.
module word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned INST_SIZE = INST_SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [7:0]           byte_data,
  output logic                 last_byte,
  output logic [INST_SIZE-1:0] word_next
);

  localparam int unsigned Bpw  = bytes_per_word(INST_SIZE);
  localparam int unsigned IdxW = (Bpw > 1) ? $clog2(Bpw) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bpw - 1);

  logic [IdxW-1:0]      idx_q;
  logic [INST_SIZE-1:0] data_q;

  assign last_byte = (idx_q == LastIdx);

  // Place the incoming byte into its lane of the partial word.
  always_comb begin
    word_next = data_q;
    for (int k = 0; k < int'(Bpw); k++) begin
      if (idx_q == IdxW'(k)) begin
        word_next[8*k +: 8] = byte_data;
      end
    end
  end

  // Byte index and partial-word register; the index wraps after the last lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (accept) begin
      data_q <= word_next;
      idx_q  <= last_byte ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams a program, byte by byte, into instruction memory and holds the core
// in reset until a complete load has finished.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned INST_MEM_DEPTH = 8,
  parameter int unsigned INST_SIZE      = BYTES_PER_WORD * 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic [INST_MEM_DEPTH:0]   load_len,
  input  logic                      load_abort,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      imem_we,
  output logic [INST_MEM_DEPTH-1:0] imem_addr,
  output logic [INST_SIZE-1:0]      imem_wdata,
  output logic                      cpu_rst,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  // Largest legal length: the whole memory.
  localparam logic [INST_MEM_DEPTH:0] MaxLen = {1'b1, {INST_MEM_DEPTH{1'b0}}};

  loader_state_e state_q, state_d;

  logic [INST_MEM_DEPTH:0]   len_q;
  logic [INST_MEM_DEPTH:0]   word_cnt_q;
  logic [INST_MEM_DEPTH:0]   word_cnt_inc;
  logic [INST_MEM_DEPTH-1:0] addr_q;
  logic [INST_SIZE-1:0]      wdata_q;
  logic                      err_q;

  logic                      len_ok;
  logic                      start_ok;
  logic                      start_bad;
  logic                      accept;
  logic                      latch_word;
  logic                      last_byte;
  logic [INST_SIZE-1:0]      word_next;

  assign len_ok       = (load_len != '0) && (load_len <= MaxLen);
  assign word_cnt_inc = word_cnt_q + 1'b1;

  word_assembler #(
    .INST_SIZE (INST_SIZE)
  ) u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .accept    (accept),
    .byte_data (byte_data),
    .last_byte (last_byte),
    .word_next (word_next)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    latch_word = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // Abort is meaningless here; start is the only request honoured.
        if (load_start) begin
          if (len_ok) begin
            start_ok = 1'b1;
            state_d  = StRecv;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      StRecv: begin
        if (load_abort) begin
          state_d = StIdle;
        end else if (byte_valid) begin
          accept = 1'b1;
          if (last_byte) begin
            latch_word = 1'b1;
            state_d    = StWrite;
          end
        end
      end
      StWrite: begin
        // The strobe for this cycle is already out; abort only redirects.
        if (load_abort) begin
          state_d = StIdle;
        end else if (word_cnt_inc == len_q) begin
          state_d = StDone;
        end else begin
          state_d = StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, length/word counters, error pulse and the write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= start_bad;
      if (start_ok) begin
        len_q      <= load_len;
        word_cnt_q <= '0;
      end else if (state_q == StWrite) begin
        word_cnt_q <= word_cnt_inc;
      end
      // Capture address and data together so both hold after the strobe.
      if (latch_word) begin
        addr_q  <= word_cnt_q[INST_MEM_DEPTH-1:0];
        wdata_q <= word_next;
      end
    end
  end

  // Outputs are pure decodes of the state plus the held write-port registers.
  always_comb begin
    byte_ready = (state_q == StRecv);
    imem_we    = (state_q == StWrite);
    busy       = (state_q == StRecv) || (state_q == StWrite);
    done       = (state_q == StDone);
    cpu_rst    = (state_q != StDone);
    err        = err_q;
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
  end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter INST_MEM_DEPTH, default 8, instruction-memory address width in bits (2^INST_MEM_DEPTH words).
REQ-002 Parameter INST_SIZE, default 32, instruction word width in bits; SHALL be a multiple of 8.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 load_start  input  1  one-cycle request to begin a load.
REQ-006 load_len  input  INST_MEM_DEPTH+1  number of words to load, sampled with load_start.
REQ-007 load_abort  input  1  cancel an in-progress load.
REQ-008 byte_valid  input  1  byte_data holds a valid byte.
REQ-009 byte_data  input  8  next instruction byte, little-endian order within each word.
REQ-010 byte_ready  output  1  loader accepts byte this cycle; transfer when byte_valid && byte_ready.
REQ-011 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-012 imem_addr  output  INST_MEM_DEPTH  word address of the write.
REQ-013 imem_wdata  output  INST_SIZE  assembled instruction word.
REQ-014 cpu_rst  output  1  reset to the processor core; high while no valid program is loaded.
REQ-015 busy  output  1  high in RECV or WRITE.
REQ-016 done  output  1  level, high in DONE.
REQ-017 err  output  1  one-cycle pulse on a rejected load_start.

Function
REQ-018 FSM states: IDLE, RECV, WRITE, DONE; the state register is the only mode state.
REQ-019 In IDLE or DONE, load_start with 1 <= load_len <= 2^INST_MEM_DEPTH SHALL latch load_len, clear the word counter and byte index, and go to RECV.
REQ-020 load_start with load_len = 0 or load_len > 2^INST_MEM_DEPTH SHALL pulse err the next cycle and leave state unchanged.
REQ-021 load_start while busy SHALL be ignored (no err).
REQ-022 byte_ready SHALL be 1 only in RECV.
REQ-023 Each accepted byte k (0..INST_SIZE/8-1) SHALL be placed at imem_wdata bits [8k+7:8k]; after the last byte of a word, go to WRITE.
REQ-024 In WRITE, imem_we = 1 for exactly one cycle with imem_addr = current word counter; write latency is one cycle after the last byte is accepted.
REQ-025 After WRITE: increment the word counter; if it equals the latched length, go to DONE, otherwise go to RECV.
REQ-026 byte_valid low in RECV SHALL stall with no state change; there is no timeout.
REQ-027 imem_we SHALL be 0 in all states except WRITE; imem_addr/imem_wdata hold their last values otherwise.
REQ-028 cpu_rst SHALL be 1 in IDLE, RECV and WRITE, and 0 only in DONE.
REQ-029 load_start in DONE SHALL reassert cpu_rst in the next cycle.
REQ-030 load_abort in RECV or WRITE SHALL return to IDLE the next cycle with done = 0 and cpu_rst = 1.
REQ-031 A WRITE cycle coinciding with load_abort SHALL still issue its strobe; the abort takes effect afterwards.
REQ-032 load_abort in IDLE or DONE SHALL be ignored.
REQ-033 load_abort and load_start together: abort wins while busy; start wins in IDLE or DONE.

Reset
REQ-034 rst SHALL force state IDLE, counters/byte index 0, imem_wdata 0, imem_addr 0, imem_we 0, byte_ready 0, busy 0, done 0, err 0, cpu_rst 1.
REQ-035 rst mid-load SHALL abandon the partial word without any write.

Structure
REQ-036 State enum and BYTES_PER_WORD = INST_SIZE/8 SHALL live in shared package loader_pkg.
REQ-037 One sub-module, word_assembler (byte index counter plus shift/placement register), SHALL be used; the FSM stays in inst_mem_loader.

Verification
REQ-038 load_len=2, bytes 13,00,00,00,93,00,10,00 -> two writes: addr 0 data 0x00000013, addr 1 data 0x00100093; done=1 and cpu_rst=0 on the cycle after the second WRITE.
REQ-039 load_len=0, then load_len=257 (DEPTH=8) -> one err pulse each; state stays IDLE; no imem_we.
REQ-040 byte_valid toggled randomly during a 4-word load -> same data and addresses as the ungapped case; exactly 4 imem_we pulses.
REQ-041 load_abort after 6 bytes of a 3-word load -> exactly 1 write, then IDLE, cpu_rst=1, done=0; a following 1-word load writes addr 0.
REQ-042 load_len=256 full load -> last write at addr 0xFF; done asserted after it.
REQ-043 rst asserted mid-word, then in DONE -> all REQ-034 values on the next cycle.
